// File: rtl/uart_rx_if.sv
// uart_rx_if: host-side bundle of the UART receiver.
//   rx_ack      consumer -> receiver, one-cycle acknowledge of the held byte
//   rx_data     last received byte
//   rx_ready    a byte is held and not yet acknowledged
//   parity_err  parity mismatch on the byte in rx_data
//   frame_err   stop bit sampled low on the byte in rx_data
//   overrun     sticky; a frame completed while rx_ready was already set
//   busy        receiver is mid-frame
// master = receiver side, slave = consumer side.
interface uart_rx_if;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx_ack,
    output rx_data, rx_ready, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output rx_ack,
    input  rx_data, rx_ready, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling serial receiver, start / 8 data LSB-first /
// optional parity / stop, with a ready/ack byte handshake.
// Build option: define UART_RX_PARITY_EN for the 11-bit frame with a parity
// bit; otherwise the frame is 10 bits and parity_err is tied low.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   rx     serial line (idles high, asynchronous to clk)
//   bus    uart_rx_if.master: rx_ack in; rx_data, rx_ready, parity_err,
//          frame_err, overrun, busy out
// Parameters: BIT_TIME clocks per bit (4..65535), PARITY_ODD (0 even, 1 odd).
module uart_rx #(
  parameter int BIT_TIME   = 5208,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  localparam logic [15:0] CNT_LAST = 16'(BIT_TIME - 1);
  localparam logic [15:0] CNT_HALF = 16'(BIT_TIME / 2 - 1);

  // [0],[1] synchronizer, [2] one-cycle delay for falling-edge detect
  logic [2:0]  sync_q, sync_d;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  logic rx_s, rx_dly, cnt_last;
  assign rx_s     = sync_q[1];
  assign rx_dly   = sync_q[2];
  assign cnt_last = (cnt_q == CNT_LAST);
  assign sync_d   = {sync_q[1:0], rx};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? 16'd0 : cnt_q + 16'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    if (bus.rx_ack && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        // edge, not level: a line stuck low cannot start a new frame
        if (rx_dly && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          if (rx_s) begin
            state_d = S_IDLE;          // start bit gone by mid-bit: glitch
          end else begin
            cnt_d   = 16'd0;           // re-phase so later samples land mid-bit
            idx_d   = 3'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = S_PARITY;
`else
          if (idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_last) begin
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_last) begin
          // completion; leaving at mid-stop gives margin for the next start edge
          state_d = S_IDLE;
          data_d  = sh_q;
          ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = ^sh_q ^ par_q ^ PARITY_ODD;
`endif
          // an ack in this same cycle consumes the old byte, so no overrun
          if (ready_q && !bus.rx_ack) ovr_d = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 3'b111;
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_ready  = ready_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
  wire unused_parity_cfg = PARITY_ODD;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: two receivers (even and odd parity) share one rx line and ack;
// frames are bit-banged at BIT_TIME=16 and compared with a frame-level model.
module tb_uart_rx;
  localparam int BT = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, rx = 1'b1, ack = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if ife ();
  uart_rx_if ifo ();
  assign ife.rx_ack = ack;
  assign ifo.rx_ack = ack;

  uart_rx #(.BIT_TIME(BT), .PARITY_ODD(1'b0)) dut_even (.clk(clk), .reset(reset), .rx(rx), .bus(ife));
  uart_rx #(.BIT_TIME(BT), .PARITY_ODD(1'b1)) dut_odd  (.clk(clk), .reset(reset), .rx(rx), .bus(ifo));

  int n_tests = 0, n_fail = 0;

  // frame-level model of the host-visible state
  logic [7:0] m_data;
  logic m_ready, m_perr_e, m_perr_o, m_ferr, m_ovr;

  function automatic logic [25:0] obs_vec();
    return {ife.rx_data, ife.rx_ready, ife.parity_err, ife.frame_err, ife.overrun, ife.busy,
            ifo.rx_data, ifo.rx_ready, ifo.parity_err, ifo.frame_err, ifo.overrun, ifo.busy};
  endfunction

  function automatic logic [25:0] exp_vec();
    return {m_data, m_ready, m_perr_e, m_ferr, m_ovr, 1'b0,
            m_data, m_ready, m_perr_o, m_ferr, m_ovr, 1'b0};
  endfunction

  task automatic model_reset();
    m_data = 8'h00; m_ready = 0; m_perr_e = 0; m_perr_o = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cyc(BT);
  endtask

  // Drives one whole frame starting at a negedge. The stop sample falls on the
  // cycle between stop-bit negedges +10 and +11; pre_* are sampled at +10,
  // post_rdy at +11. ack_done pulses rx_ack on that completion cycle.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input bit ack_done, output logic pre_rdy,
                            output logic pre_busy, output logic post_rdy);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(pbit);
    rx = stop;
    cyc(10);
    pre_rdy  = ife.rx_ready;
    pre_busy = ife.busy;
    if (ack_done) ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    post_rdy = ife.rx_ready;
    if (m_ready) m_ovr = !ack_done;
    m_ready  = 1'b1;
    m_data   = d;
    m_ferr   = !stop;
    m_perr_e = PAR_EN ? (^d ^ pbit) : 1'b0;
    m_perr_o = PAR_EN ? ~(^d ^ pbit) : 1'b0;
    cyc(5);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    if (m_ready) begin m_ready = 0; m_ovr = 0; end
  endtask

  task automatic test_reset();
    logic [25:0] o;
    reset = 1'b0;
    model_reset();
    cyc(3);
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL reset_state: got %h want %h", o, exp_vec()); end
    n_tests++;
    reset = 1'b1;
    cyc(3);
  endtask

  task automatic test_basic();
    logic a, b, c;
    logic [25:0] o;
    send_frame(8'hA5, 1'b0, 1'b1, 0, a, b, c);
    if ({a, b, c} !== 3'b011) begin n_fail++; $display("FAIL ready_timing: got %b want 011", {a, b, c}); end
    n_tests++;
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL basic_a5: got %h want %h", o, exp_vec()); end
    n_tests++;
    do_ack();
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL ack_clear: got %h want %h", o, exp_vec()); end
    n_tests++;
  endtask

  task automatic test_parity();
    logic a, b, c;
    logic [25:0] o;
    send_frame(8'h3C, 1'b1, 1'b1, 0, a, b, c);
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL parity_3c: got %h want %h", o, exp_vec()); end
    n_tests++;
    do_ack();
  endtask

  task automatic test_framing();
    logic a, b, c;
    logic [25:0] o;
    bit saw_busy;
    send_frame(8'h55, 1'b0, 1'b0, 0, a, b, c);
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL frame_err_55: got %h want %h", o, exp_vec()); end
    n_tests++;
    do_ack();
    saw_busy = 0;
    for (int i = 0; i < 40; i++) begin cyc(1); saw_busy |= ife.busy | ifo.busy; end
    if ({saw_busy, ife.rx_ready} !== 2'b00) begin
      n_fail++; $display("FAIL held_low_no_frame: got %b want 00", {saw_busy, ife.rx_ready});
    end
    n_tests++;
    rx = 1'b1;
    cyc(4);
    send_frame(8'h01, 1'b1, 1'b1, 0, a, b, c);
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL after_low_01: got %h want %h", o, exp_vec()); end
    n_tests++;
    do_ack();
  endtask

  task automatic test_glitch();
    logic [25:0] o;
    bit saw_busy;
    saw_busy = 0;
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin cyc(1); saw_busy |= ife.busy; end
    if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b want 1", saw_busy); end
    n_tests++;
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL glitch_idle: got %h want %h", o, exp_vec()); end
    n_tests++;
  endtask

  task automatic test_back_to_back();
    logic a, b, c;
    logic [25:0] o;
    send_frame(8'h11, 1'b0, 1'b1, 0, a, b, c);
    send_frame(8'h22, 1'b0, 1'b1, 0, a, b, c);
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL overrun_set: got %h want %h", o, exp_vec()); end
    n_tests++;
    do_ack();
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL overrun_ack: got %h want %h", o, exp_vec()); end
    n_tests++;
    send_frame(8'h11, 1'b0, 1'b1, 0, a, b, c);
    send_frame(8'h22, 1'b0, 1'b1, 1, a, b, c);
    if ({ife.overrun, ife.rx_ready, ife.rx_data} !== {2'b01, 8'h22}) begin
      n_fail++; $display("FAIL ack_at_done: got %b want 01_22", {ife.overrun, ife.rx_ready, ife.rx_data});
    end
    n_tests++;
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL ack_at_done_all: got %h want %h", o, exp_vec()); end
    n_tests++;
  endtask

  task automatic test_reset_mid();
    logic a, b, c;
    logic [25:0] o;
    logic [7:0] d;
    d = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    cyc(8);
    if (ife.busy !== 1'b1) begin n_fail++; $display("FAIL mid_frame_busy: got %b want 1", ife.busy); end
    n_tests++;
    reset = 1'b0;
    model_reset();
    #1;
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL reset_mid: got %h want %h", o, exp_vec()); end
    n_tests++;
    rx = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(3);
    send_frame(8'hF0, 1'b0, 1'b1, 0, a, b, c);
    o = obs_vec();
    if (o !== exp_vec()) begin n_fail++; $display("FAIL after_reset_f0: got %h want %h", o, exp_vec()); end
    n_tests++;
    do_ack();
  endtask

  task automatic test_random();
    logic a, b, c, stop, pbit;
    logic [25:0] o;
    logic [7:0] d;
    bit ackd;
    int g;
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      pbit = ^d ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      ackd = ($urandom_range(0, 3) == 0);
      send_frame(d, pbit, stop, ackd, a, b, c);
      o = obs_vec();
      if (o !== exp_vec()) begin n_fail++; $display("FAIL random_%0d: got %h want %h", n, o, exp_vec()); end
      n_tests++;
      if ($urandom_range(0, 2) == 0) do_ack();
      g = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      rx = 1'b1;
      cyc(g);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the Nexys2 UART link; the receive-side counterpart of the 11-bit parallel-in/serial-out transmit frame. Frames are start(0), 8 data bits LSB-first, optional parity, and stop(1). The receiver recovers each frame from the `rx` line by mid-bit sampling and presents the byte on a ready/ack handshake. It also reports parity, framing and overrun status to the host logic.

## Interface
- `BIT_TIME`, default 5208: clocks per bit (50 MHz / 9600 baud). Legal range 4..65535.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity. Ignored when parity is compiled out.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line; idles high; asynchronous to `clk`.
- `rx_ack` in 1: one-cycle pulse from the consumer; acknowledges the held byte.
- `rx_data` out 8: last received byte.
- `rx_ready` out 1: level; a byte is held and has not yet been acknowledged.
- `parity_err` out 1: parity mismatch on the frame in `rx_data`.
- `frame_err` out 1: stop bit sampled 0 on the frame in `rx_data`.
- `overrun` out 1: sticky; a frame completed while `rx_ready` was already 1.
- `busy` out 1: receiver is mid-frame (any state other than IDLE).

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer, giving `rx_s`. A third flop holds `rx_s` delayed by one cycle for edge detection. All three flops reset to 1.
- **Bit counter:** counts 0..`BIT_TIME`-1 and wraps.
- **Bit index:** counts 0..7.
- **Shift register:** 8 bits, right-shifting; `sh <= {rx_s, sh[7:1]}`. The first data bit received ends up in `sh[0]`.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge of `rx_s` (delayed = 1, `rx_s` = 0), clear the bit counter and go to START. A line held low does not retrigger; a new frame needs a new falling edge.
  - START: at count `BIT_TIME/2`-1 (integer division), sample `rx_s`.
    - If 1, treat as a glitch: return to IDLE with no flags changed.
    - If 0, clear the counter, clear the bit index, go to DATA.
  - DATA: at count `BIT_TIME`-1, shift in `rx_s`. After index 7, go to PARITY, or to STOP when parity is compiled out.
  - PARITY: at count `BIT_TIME`-1, latch `rx_s` as the parity bit, then go to STOP.
  - STOP: at count `BIT_TIME`-1, sample `rx_s` and complete the frame, then go to IDLE in the same cycle.
- **Frame completion (one cycle):**
  - `rx_data <= sh`.
  - `frame_err <= ~rx_s`.
  - `parity_err <= (^sh ^ parity_bit ^ PARITY_ODD)`.
  - `rx_ready <= 1`.
  - If `rx_ready` was already 1 and `rx_ack` is not asserted in that cycle, set `overrun`.
  - A byte is delivered even when an error flag is set.
- **`rx_ack` handling:**
  - `rx_ack` while `rx_ready` = 1 clears `rx_ready` and `overrun`. `rx_data` and the error flags hold their values.
  - `rx_ack` while `rx_ready` = 0 has no effect.
  - `rx_ack` in the same cycle as completion: completion wins. `rx_ready` stays 1, the new byte is loaded, and `overrun` is not set.
- **Reset values:** `rx_data` = 8'h00; `rx_ready`, `parity_err`, `frame_err`, `overrun`, `busy` = 0; state = IDLE.
- **Reset mid-frame:** abandons the frame immediately; no flag is updated.

## Timing
- Let cycle T be the first cycle in which `rx_s` = 0 with the delayed flop = 1. T is 2 to 3 clocks after the `rx` pin falls.
- Start-bit check: T + `BIT_TIME/2`.
- Data bit k (k = 0..7) sampled at T + `BIT_TIME/2` + (k+1)·`BIT_TIME`.
- Parity bit sampled at + 9·`BIT_TIME`.
- Stop bit sampled at + 10·`BIT_TIME`, or + 9·`BIT_TIME` without parity.
- `rx_ready` and the other outputs update on the clock edge after the stop sample.
- `busy` is high from T+1 through the stop-sample cycle.
- Back-to-back frames are accepted: IDLE is re-entered at mid-stop, leaving half a bit of margin before the next start edge.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - 11-bit frame with PARITY state.
  - `parity_err` is computed as above.
- `UART_RX_PARITY_EN` undefined:
  - 10-bit frame; the PARITY state and parity latch are not built.
  - `parity_err` is tied to 0.
  - Stop bit is sampled at + 9·`BIT_TIME`.

## Test plan
All scenarios use `BIT_TIME` = 16, parity enabled, even parity unless noted.
- Send 0xA5 with parity 0 and stop 1 → `rx_data` = 0xA5, `rx_ready` = 1, `parity_err` = 0, `frame_err` = 0. `rx_ready` rises 1 clock after the stop sample.
- Send 0x3C with parity 1 (wrong for even) → `rx_data` = 0x3C, `parity_err` = 1. Repeat with `PARITY_ODD` = 1 → `parity_err` = 0.
- Send 0x55 with stop bit 0 → `frame_err` = 1. Then hold `rx` low 40 clocks → no further frame. Then return `rx` high and send 0x01 → `rx_data` = 0x01, `frame_err` = 0.
- Drive a 3-clock low glitch on `rx` → `busy` pulses, then returns to IDLE; `rx_ready` stays 0.
- Send two frames, 0x11 then 0x22, without `rx_ack` → `rx_data` = 0x22, `overrun` = 1. Pulse `rx_ack` → `rx_ready` = 0, `overrun` = 0. Repeat with `rx_ack` in the completion cycle of the second frame → `overrun` stays 0, `rx_ready` = 1.
- Assert `reset` low during data bit 4 → all outputs return to reset values. Then a clean 0xF0 frame → `rx_data` = 0xF0.
